// File: rtl/noc_pkg.sv
// Shared definitions for the NoC traffic generator/checker node.
package noc_pkg;

    // Address-event packet layout (low 32 bits of a flit)
    localparam int PKT_W    = 32;
    localparam int FIELD_W  = 4;
    localparam int TS_W     = 16;
    localparam int DROW_LSB = 28;
    localparam int DCOL_LSB = 24;
    localparam int SROW_LSB = 20;
    localparam int SCOL_LSB = 16;
    localparam int TS_LSB   = 0;

    typedef enum logic [1:0] {
        MODE_UNIFORM   = 2'd0,
        MODE_TRANSPOSE = 2'd1,
        MODE_HOTSPOT   = 2'd2,
        MODE_EAST      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: feedback is
    // the XOR of bits 0,2,3,5 and enters at bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR that steps only when asked to.
module noc_lfsr16
    import noc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] seed_i,
    input  logic        advance_i,
    output logic [15:0] value_o
);

    logic [15:0] value_q;

    // Load the seed on reset, shift one step per advance request.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            value_q <= seed_i;
        else if (advance_i)
            value_q <= {^(value_q & LFSR_TAPS), value_q[15:1]};
    end

    assign value_o = value_q;

endmodule

// File: rtl/noc_traffic_node.sv
// Per-node traffic injector and delivery checker for the spiking NoC mesh.
module noc_traffic_node
    import noc_pkg::*;
#(
    parameter int          ROWS       = 2,
    parameter int          COLS       = 2,
    parameter int          DATA_WIDTH = 32,
    parameter int          MY_ROW     = 0,
    parameter int          MY_COL     = 0,
    parameter int          HOT_ROW    = 0,
    parameter int          HOT_COL    = 0,
    parameter logic [15:0] SEED       = 16'hACE1
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [15:0]           num_packets_i,
    input  logic [7:0]            gap_i,
    input  logic                  stats_clear_i,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           sent_count_o,
    output logic [15:0]           recv_count_o,
    output logic [31:0]           latency_sum_o,
    output logic [15:0]           latency_max_o,
    output logic [15:0]           misroute_count_o
);

    localparam int          RB        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int          CB        = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [3:0]  ROW_MASK  = 4'((1 << RB) - 1);
    localparam logic [3:0]  COL_MASK  = 4'((1 << CB) - 1);
    localparam logic [3:0]  MY_R      = 4'(MY_ROW);
    localparam logic [3:0]  MY_C      = 4'(MY_COL);
    localparam logic [3:0]  HOT_R     = 4'(HOT_ROW);
    localparam logic [3:0]  HOT_C     = 4'(HOT_COL);
    localparam logic [3:0]  EAST_C    = 4'((MY_COL + 1) % COLS);
    localparam logic [15:0] SEED_MIX  = SEED ^ {8'h00, MY_R, MY_C};
    localparam logic [15:0] LFSR_INIT = (SEED_MIX == 16'h0) ? SEED : SEED_MIX;
    // Fixed patterns that would address this node itself produce no traffic
    localparam bit TRANS_SELF = (MY_ROW == MY_COL);
    localparam bit HOT_SELF   = (HOT_ROW == MY_ROW) && (HOT_COL == MY_COL);
    localparam bit EAST_SELF  = (COLS == 1);

    state_e      state_q, state_d;
    mode_e       mode_q, mode_d;
    logic [15:0] num_q, num_d, sent_q, sent_d, ts_q, ts_d, cyc_q;
    logic [7:0]  gap_q, gap_d, gcnt_q, gcnt_d;
    logic        advance, fixed_self;
    logic [15:0] lfsr;
    logic [4:0]  r5, c5;
    logic [3:0]  dst_r, dst_c;

    logic [15:0] recv_q, recv_d, lmax_q, lmax_d, mis_q, mis_d, lat;
    logic [31:0] lsum_q, lsum_d;
    logic [32:0] sum_ext;
    logic        rx_rdy_q, rx_fire;
    logic        unused_bits;

    noc_lfsr16 u_lfsr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .seed_i    (LFSR_INIT),
        .advance_i (advance),
        .value_o   (lfsr)
    );

    // Does the requested fixed pattern point back at this node?
    always_comb begin
        fixed_self = 1'b0;
        case (mode_e'(mode_i))
            MODE_TRANSPOSE: fixed_self = TRANS_SELF;
            MODE_HOTSPOT:   fixed_self = HOT_SELF;
            MODE_EAST:      fixed_self = EAST_SELF;
            default:        fixed_self = 1'b0;
        endcase
    end

    // Destination for the packet currently offered; lfsr and mode_q only
    // change between packets, so this stays stable while stalled.
    always_comb begin
        r5 = {1'b0, lfsr[7:4] & ROW_MASK};
        c5 = {1'b0, lfsr[3:0] & COL_MASK};
        if (r5 >= 5'(ROWS)) r5 = r5 - 5'(ROWS);
        if (c5 >= 5'(COLS)) c5 = c5 - 5'(COLS);
        if (r5[3:0] == MY_R && c5[3:0] == MY_C)
            c5 = (c5 + 5'd1 == 5'(COLS)) ? 5'd0 : c5 + 5'd1;
        dst_r = r5[3:0];
        dst_c = c5[3:0];
        case (mode_q)
            MODE_TRANSPOSE: begin dst_r = MY_C; dst_c = MY_R;   end
            MODE_HOTSPOT:   begin dst_r = HOT_R; dst_c = HOT_C; end
            MODE_EAST:      begin dst_r = MY_R; dst_c = EAST_C; end
            default: ;
        endcase
    end

    // Injection FSM: next state, run parameters, gap timer, timestamp capture.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        num_d   = num_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        sent_d  = sent_q;
        ts_d    = ts_q;
        advance = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    mode_d = mode_e'(mode_i);
                    num_d  = num_packets_i;
                    gap_d  = gap_i;
                    sent_d = 16'd0;
                    if (num_packets_i == 16'd0 || fixed_self) begin
                        state_d = ST_DONE;
                    end else if (gap_i != 8'd0) begin
                        state_d = ST_GAP;
                        gcnt_d  = gap_i - 8'd1;
                    end else begin
                        state_d = ST_SEND;
                        ts_d    = cyc_q + 16'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gcnt_q == 8'd0) begin
                    state_d = ST_SEND;
                    ts_d    = cyc_q + 16'd1;
                end else begin
                    gcnt_d = gcnt_q - 8'd1;
                end
            end
            ST_SEND: begin
                if (tx_ready_i) begin
                    advance = 1'b1;
                    sent_d  = sent_q + 16'd1;
                    if (sent_d == num_q) begin
                        state_d = ST_DONE;
                    end else if (gap_q != 8'd0) begin
                        state_d = ST_GAP;
                        gcnt_d  = gap_q - 8'd1;
                    end else begin
                        ts_d = cyc_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Receive statistics; a clear in the same cycle as an arrival keeps
    // only that arrival.
    always_comb begin
        recv_d  = stats_clear_i ? 16'd0 : recv_q;
        lsum_d  = stats_clear_i ? 32'd0 : lsum_q;
        lmax_d  = stats_clear_i ? 16'd0 : lmax_q;
        mis_d   = stats_clear_i ? 16'd0 : mis_q;
        lat     = cyc_q - rx_data_i[TS_LSB +: TS_W];
        sum_ext = '0;
        if (rx_fire) begin
            recv_d  = sat_inc16(recv_d);
            sum_ext = {1'b0, lsum_d} + {17'b0, lat};
            lsum_d  = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
            if (lat > lmax_d) lmax_d = lat;
            if (rx_data_i[DROW_LSB +: FIELD_W] != MY_R ||
                rx_data_i[DCOL_LSB +: FIELD_W] != MY_C)
                mis_d = sat_inc16(mis_d);
        end
    end

    assign rx_fire = rx_valid_i && rx_rdy_q;

    // All state registers, cleared synchronously.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_UNIFORM;
            num_q    <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            sent_q   <= '0;
            ts_q     <= '0;
            cyc_q    <= '0;
            recv_q   <= '0;
            lsum_q   <= '0;
            lmax_q   <= '0;
            mis_q    <= '0;
            rx_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            num_q    <= num_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            sent_q   <= sent_d;
            ts_q     <= ts_d;
            cyc_q    <= cyc_q + 16'd1;
            recv_q   <= recv_d;
            lsum_q   <= lsum_d;
            lmax_q   <= lmax_d;
            mis_q    <= mis_d;
            rx_rdy_q <= 1'b1;
        end
    end

    assign tx_valid_o       = (state_q == ST_SEND);
    assign tx_data_o        = tx_valid_o ? DATA_WIDTH'({dst_r, dst_c, MY_R, MY_C, ts_q}) : '0;
    assign rx_ready_o       = rx_rdy_q;
    assign busy_o           = (state_q == ST_GAP) || (state_q == ST_SEND);
    assign done_o           = (state_q == ST_DONE);
    assign sent_count_o     = sent_q;
    assign recv_count_o     = recv_q;
    assign latency_sum_o    = lsum_q;
    assign latency_max_o    = lmax_q;
    assign misroute_count_o = mis_q;

    // Source fields, upper flit bits and high LFSR bits carry no meaning here
    assign unused_bits = ^{rx_data_i, lfsr[15:8]};

endmodule

// File: tb/tb_noc_traffic_node.sv
// Randomized scoreboard bench for noc_traffic_node on a 2x2 mesh at node (0,0).
module tb_noc_traffic_node;

    logic        clk = 1'b0;
    logic        rst, start, stats_clear, tx_valid, tx_ready, rx_valid, rx_ready;
    logic        busy, done;
    logic [1:0]  mode;
    logic [15:0] num_packets, sent_count, recv_count, latency_max, misroute_count;
    logic [7:0]  gap;
    logic [31:0] tx_data, rx_data, latency_sum;

    always #5 clk = ~clk;

    noc_traffic_node #(
        .ROWS(2), .COLS(2), .DATA_WIDTH(32), .MY_ROW(0), .MY_COL(0),
        .HOT_ROW(0), .HOT_COL(0), .SEED(16'hACE1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .num_packets_i(num_packets), .gap_i(gap), .stats_clear_i(stats_clear),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
        .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data),
        .busy_o(busy), .done_o(done), .sent_count_o(sent_count),
        .recv_count_o(recv_count), .latency_sum_o(latency_sum),
        .latency_max_o(latency_max), .misroute_count_o(misroute_count)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference cycle count: zero while in reset, +1 per clock afterwards
    logic [15:0] bcyc;
    always @(posedge clk) bcyc <= rst ? 16'd0 : bcyc + 16'd1;

    typedef struct { bit rng; logic [15:0] hdr; } txexp_t;
    typedef struct { logic [15:0] rc; logic [31:0] ls; logic [15:0] lm; logic [15:0] mr; } rxexp_t;
    txexp_t txq[$];
    rxexp_t rxq[$];

    // Receive statistics model
    logic [15:0] m_recv = 0, m_max = 0, m_mis = 0;
    logic [31:0] m_sum = 0;

    task automatic rx_model(input bit v, input bit clr, input logic [31:0] d, input logic [15:0] c);
        logic [15:0] l;
        longint s;
        rxexp_t e;
        if (clr) begin m_recv = 0; m_sum = 0; m_max = 0; m_mis = 0; end
        if (v) begin
            l = c - d[15:0];
            if (m_recv != 16'hFFFF) m_recv = m_recv + 1;
            s = longint'(m_sum) + longint'(l);
            m_sum = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
            if (l > m_max) m_max = l;
            if (d[31:24] != 8'h00 && m_mis != 16'hFFFF) m_mis = m_mis + 1;
        end
        if (v || clr) begin
            e.rc = m_recv; e.ls = m_sum; e.lm = m_max; e.mr = m_mis;
            rxq.push_back(e);
        end
    endtask

    // Drive one rx cycle starting at a negedge; returns at the next negedge
    task automatic rx_cycle(input bit v, input bit clr, input logic [31:0] d);
        rx_valid    = v;
        stats_clear = clr;
        rx_data     = d;
        rx_model(v, clr, d, bcyc);
        @(negedge clk);
        rx_valid    = 1'b0;
        stats_clear = 1'b0;
    endtask

    // Monitor: samples a little after the negedge when inputs and outputs are settled
    bit          in_pkt = 0, rx_due = 0;
    logic [31:0] held;
    logic [3:0]  seen_mask = 0;
    txexp_t      te;
    rxexp_t      re;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            in_pkt = 0;
            rx_due = 0;
        end else begin
            if (rx_due && rxq.size() > 0) begin
                re = rxq.pop_front();
                chk("recv_count", recv_count, re.rc);
                chk("latency_sum", latency_sum, re.ls);
                chk("latency_max", latency_max, re.lm);
                chk("misroute_count", misroute_count, re.mr);
            end
            rx_due = (rx_valid && rx_ready) || stats_clear;
            if (tx_valid) begin
                if (!in_pkt) begin
                    in_pkt = 1;
                    held   = tx_data;
                    chk("tx_timestamp", tx_data[15:0], bcyc);
                end else begin
                    chk("tx_stable", tx_data, held);
                end
                if (tx_ready) begin
                    in_pkt = 0;
                    chk("tx_src", tx_data[23:16], 8'h00);
                    if (txq.size() == 0) begin
                        chk("tx_unexpected", 1, 0);
                    end else begin
                        te = txq.pop_front();
                        if (te.rng) begin
                            chk("dest_in_range",
                                (tx_data[31:28] < 2) && (tx_data[27:24] < 2) &&
                                (tx_data[31:24] != 8'h00), 1);
                            seen_mask[{tx_data[28], tx_data[24]}] = 1'b1;
                        end else begin
                            chk("tx_dest", tx_data[31:24], te.hdr[15:8]);
                        end
                    end
                end
            end
        end
    end

    task automatic push_tx(input bit rng, input logic [15:0] hdr, input int n);
        txexp_t e;
        e.rng = rng;
        e.hdr = hdr;
        for (int i = 0; i < n; i++) txq.push_back(e);
    endtask

    initial begin
        logic [31:0] d;
        bit ok;
        rst = 1; start = 0; mode = 0; num_packets = 0; gap = 0; stats_clear = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sent", sent_count, 0);
        chk("rst_stats", {recv_count, latency_max, misroute_count}, 0);
        chk("rst_lat_sum", latency_sum, 0);
        rst = 0;
        @(negedge clk);
        chk("rx_ready_after_rst", rx_ready, 1);

        // Rx: ts FFFE accepted at cyc 3 gives latency 5
        for (int i = 0; i < 10 && bcyc != 16'd3; i++) @(negedge clk);
        chk("reach_cyc3", bcyc, 3);
        rx_cycle(1, 0, 32'h0000_FFFE);
        #3;
        chk("example_lat_sum", latency_sum, 5);
        chk("example_lat_max", latency_max, 5);
        chk("example_misroute", misroute_count, 0);
        @(negedge clk);
        rx_cycle(1, 0, {8'h10, 8'h00, bcyc - 16'd1});
        #3;
        chk("example_misroute2", misroute_count, 1);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            if ($urandom_range(0, 1) == 1) d[31:24] = {3'b0, 1'($urandom), 3'b0, 1'($urandom)};
            rx_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, d);
        end
        @(negedge clk);

        // Mode3 timing: gap 2, three packets east to (0,1)
        tx_ready = 1; mode = 3; num_packets = 3; gap = 2; start = 1;
        push_tx(0, 16'h0100, 3);
        @(negedge clk);
        start = 0;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("east_valid_k%0d", k), tx_valid, (k % 3 == 0) && (k < 10));
            if (k == 9) chk("east_done_early", done, 0);
            if (k == 10) begin
                chk("east_done", done, 1);
                chk("east_sent", sent_count, 3);
                chk("east_busy", busy, 0);
            end
            @(negedge clk);
        end

        // Backpressure: four stalled cycles, then two back-to-back handshakes
        tx_ready = 0; mode = 3; num_packets = 2; gap = 0; start = 1;
        push_tx(0, 16'h0100, 2);
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", tx_valid, 1);
            chk("stall_sent", sent_count, 0);
            @(negedge clk);
        end
        tx_ready = 1;
        @(negedge clk);
        chk("bp_sent_one", sent_count, 1);
        @(negedge clk);
        chk("bp_sent_two", sent_count, 2);
        chk("bp_done", done, 1);

        // Hotspot onto self: finishes at once without traffic
        mode = 2; num_packets = 5; gap = 0; start = 1;
        @(negedge clk);
        start = 0;
        chk("hot_done", done, 1);
        chk("hot_sent", sent_count, 0);
        chk("hot_busy", busy, 0);
        chk("hot_valid", tx_valid, 0);
        repeat (3) @(negedge clk);

        // Uniform random with random backpressure
        mode = 0; num_packets = 50; gap = 8'($urandom_range(0, 2)); start = 1;
        push_tx(1, 16'h0, 50);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = 0;
            tx_ready = 1'($urandom);
            if (done) begin ok = 1; break; end
        end
        chk("uniform_finished", ok, 1);
        chk("uniform_sent", sent_count, 50);
        chk("uniform_spread", $countones(seen_mask) > 1, 1);

        // Reset in the middle of a run
        tx_ready = 0; mode = 0; num_packets = 50; gap = 0; start = 1;
        @(negedge clk);
        start = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("midrun_reached_send", ok, 1);
        rst = 1;
        @(negedge clk);
        txq.delete();
        rxq.delete();
        m_recv = 0; m_sum = 0; m_max = 0; m_mis = 0;
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sent", sent_count, 0);
        chk("midrst_recv", recv_count, 0);
        rst = 0;
        @(negedge clk);

        // Node still works after the reset
        tx_ready = 1; mode = 3; num_packets = 1; gap = 1; start = 1;
        push_tx(0, 16'h0100, 1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 0;
            if (done) begin ok = 1; break; end
        end
        chk("post_rst_done", ok, 1);
        chk("post_rst_sent", sent_count, 1);
        rx_cycle(1, 0, {16'h0000, bcyc - 16'd2});
        #3;
        chk("post_rst_recv", recv_count, 1);
        chk("post_rst_lat", latency_sum, 2);
        @(negedge clk);
        @(negedge clk);
        chk("tx_queue_drained", txq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
